// File: rtl/ln_stat_accum.sv
`default_nettype none
// =============================================================================
// ln_stat_accum : per-pixel sum / sum-of-squares of LayerNorm read responses,
//                 accumulated across channel groups and emitted in raster order.
// Revision      : 1.0
// =============================================================================
module ln_stat_accum #(
    parameter int TOUT       = 8,
    parameter int DAT_DW     = 16,
    parameter int LOG2_BURST = 4,
    parameter int CH_GRP_W   = 8,
    parameter int HW_W       = 12,
    parameter int SUM_DW     = 32,
    parameter int SQ_DW      = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CH_GRP_W-1:0]    ch_in_div_tout,
    input  logic [HW_W-1:0]        h_in,
    input  logic [HW_W-1:0]        w_in,
    input  logic                   rd_rsp_vld,
    output logic                   rd_rsp_rdy,
    input  logic [TOUT*DAT_DW-1:0] rd_rsp_pd,
    output logic                   stat_vld,
    input  logic                   stat_rdy,
    output logic [SUM_DW-1:0]      stat_sum,
    output logic [SQ_DW-1:0]       stat_sqsum,
    output logic                   stat_last,
    output logic                   busy,
    output logic                   done
);
    localparam int BURST = 1 << LOG2_BURST;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CH_GRP_W-1:0]   ch_cfg_q, ch_cfg_d;
    logic [HW_W-1:0]       h_cfg_q, h_cfg_d;
    logic [HW_W-1:0]       w_cfg_q, w_cfg_d;
    logic [HW_W-1:0]       h_cnt_q, h_cnt_d;
    logic [HW_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [CH_GRP_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic [LOG2_BURST-1:0] beat_cnt_q, beat_cnt_d;
    logic [LOG2_BURST-1:0] drain_cnt_q, drain_cnt_d;
    logic [SUM_DW-1:0]     sum_q, sum_d;
    logic [SQ_DW-1:0]      sq_q, sq_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;

    logic [SUM_DW-1:0]     acc_sum_q [BURST];
    logic [SQ_DW-1:0]      acc_sq_q  [BURST];

    logic [HW_W-1:0]       w_m1;
    logic                  last_burst;
    logic                  last_row;
    logic [LOG2_BURST-1:0] cur_len;
    logic [LOG2_BURST-1:0] drain_nxt;
    logic                  beat_fire;
    logic signed [DAT_DW-1:0]   elem;
    logic signed [2*DAT_DW-1:0] elem_ext;
    logic [2*DAT_DW-1:0]   prod;
    logic [SUM_DW-1:0]     beat_sum;
    logic [SQ_DW-1:0]      beat_sq;
    logic [SUM_DW-1:0]     acc_new_sum;
    logic [SQ_DW-1:0]      acc_new_sq;

    assign w_m1       = w_cfg_q - HW_W'(1);
    assign last_burst = (burst_cnt_q == (w_m1 >> LOG2_BURST));
    assign last_row   = (h_cnt_q == h_cfg_q - HW_W'(1));
    assign cur_len    = last_burst ? w_m1[LOG2_BURST-1:0] : {LOG2_BURST{1'b1}};
    assign drain_nxt  = drain_cnt_q + LOG2_BURST'(1);
    assign beat_fire  = rd_rsp_vld && (state_q == S_ACC);

    always_comb begin
        beat_sum = '0;
        beat_sq  = '0;
        elem     = '0;
        elem_ext = '0;
        prod     = '0;
        for (int k = 0; k < TOUT; k++) begin
            elem     = rd_rsp_pd[k*DAT_DW +: DAT_DW];
            elem_ext = {{DAT_DW{elem[DAT_DW-1]}}, elem};
            prod     = elem_ext * elem_ext;
            beat_sum = beat_sum + {{(SUM_DW-DAT_DW){elem[DAT_DW-1]}}, elem};
            beat_sq  = beat_sq + {{(SQ_DW-2*DAT_DW){1'b0}}, prod};
        end
    end

    // Channel group 0 overwrites the entry, so stale contents never leak in.
    assign acc_new_sum = ((ch_cnt_q == '0) ? '0 : acc_sum_q[beat_cnt_q]) + beat_sum;
    assign acc_new_sq  = ((ch_cnt_q == '0) ? '0 : acc_sq_q[beat_cnt_q]) + beat_sq;

    always_ff @(posedge clk) begin
        if (beat_fire) begin
            acc_sum_q[beat_cnt_q] <= acc_new_sum;
            acc_sq_q[beat_cnt_q]  <= acc_new_sq;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_cfg_d    = ch_cfg_q;
        h_cfg_d     = h_cfg_q;
        w_cfg_d     = w_cfg_q;
        h_cnt_d     = h_cnt_q;
        burst_cnt_d = burst_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        sum_d       = sum_q;
        sq_d        = sq_q;
        last_d      = last_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_cfg_d    = ch_in_div_tout;
                    h_cfg_d     = h_in;
                    w_cfg_d     = w_in;
                    h_cnt_d     = '0;
                    burst_cnt_d = '0;
                    ch_cnt_d    = '0;
                    beat_cnt_d  = '0;
                    if (ch_in_div_tout == '0 || h_in == '0 || w_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (rd_rsp_vld) begin
                    if (beat_cnt_q == cur_len) begin
                        beat_cnt_d = '0;
                        if (ch_cnt_q == ch_cfg_q - CH_GRP_W'(1)) begin
                            ch_cnt_d    = '0;
                            drain_cnt_d = '0;
                            state_d     = S_DRAIN;
                            // A one-pixel burst's only entry is being written this cycle.
                            sum_d  = (cur_len == '0) ? acc_new_sum : acc_sum_q[0];
                            sq_d   = (cur_len == '0) ? acc_new_sq  : acc_sq_q[0];
                            last_d = last_burst && last_row && (cur_len == '0);
                        end else begin
                            ch_cnt_d = ch_cnt_q + CH_GRP_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LOG2_BURST'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (stat_rdy) begin
                    if (drain_cnt_q == cur_len) begin
                        last_d = 1'b0;
                        if (last_burst && last_row) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = S_ACC;
                            ch_cnt_d   = '0;
                            beat_cnt_d = '0;
                            if (last_burst) begin
                                burst_cnt_d = '0;
                                h_cnt_d     = h_cnt_q + HW_W'(1);
                            end else begin
                                burst_cnt_d = burst_cnt_q + HW_W'(1);
                            end
                        end
                    end else begin
                        drain_cnt_d = drain_nxt;
                        sum_d       = acc_sum_q[drain_nxt];
                        sq_d        = acc_sq_q[drain_nxt];
                        last_d      = last_burst && last_row && (drain_nxt == cur_len);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_cfg_q    <= '0;
            h_cfg_q     <= '0;
            w_cfg_q     <= '0;
            h_cnt_q     <= '0;
            burst_cnt_q <= '0;
            ch_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            sum_q       <= '0;
            sq_q        <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_cfg_q    <= ch_cfg_d;
            h_cfg_q     <= h_cfg_d;
            w_cfg_q     <= w_cfg_d;
            h_cnt_q     <= h_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            sum_q       <= sum_d;
            sq_q        <= sq_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign rd_rsp_rdy = (state_q == S_ACC);
    assign stat_vld   = (state_q == S_DRAIN);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign stat_sum   = sum_q;
    assign stat_sqsum = sq_q;
    assign stat_last  = last_q;

endmodule
`default_nettype wire
